// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one 16-bit memory port between instruction fetch and
//               the memory stage. Data wins by default, and fetch is forced
//               a grant after STARVE_LIMIT consecutive data grants.
// Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic        dm_en32,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        stall_fetch,
    output logic        stall_mem
);

    localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);
    localparam logic c_OWNER_FETCH = 1'b0;
    localparam logic c_OWNER_DATA  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_A0   = 2'd1,
        ST_A1   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic               r_owner;
    logic               r_wide;
    logic               r_we;
    logic [31:0]        r_base;
    logic [31:0]        r_wdata;
    logic [15:0]        r_resultHi;
    logic [c_CNT_W-1:0] r_starveCnt;
    logic [31:0]        r_ifRdata;
    logic [31:0]        r_dmRdata;

    logic               w_starved;
    logic               w_grantFetch;
    logic               w_accept;
    logic [31:0]        w_readResult;

    assign w_starved    = (r_starveCnt == c_STARVE_MAX);
    assign w_grantFetch = if_req & (~dm_req | w_starved);
    assign w_accept     = (r_state == ST_IDLE) & (if_req | dm_req);

    // mem_rdata always carries the beat issued in the previous cycle.
    assign w_readResult = r_wide ? {r_resultHi, mem_rdata} : {16'h0000, mem_rdata};

    assign if_done     = (r_state == ST_FIN) & (r_owner == c_OWNER_FETCH);
    assign dm_done     = (r_state == ST_FIN) & (r_owner == c_OWNER_DATA);
    assign stall_fetch = if_req & ~if_done;
    assign stall_mem   = dm_req & ~dm_done;
    assign if_rdata    = r_ifRdata;
    assign dm_rdata    = r_dmRdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'h0000_0000;
        mem_wdata   = 16'h0000;
        case (r_state)
            ST_IDLE: begin
                if (if_req | dm_req) begin
                    w_nextState = ST_A0;
                end
            end
            ST_A0: begin
                mem_en      = 1'b1;
                mem_we      = r_we;
                mem_addr    = r_base;
                mem_wdata   = r_wide ? r_wdata[31:16] : r_wdata[15:0];
                w_nextState = r_wide ? ST_A1 : ST_FIN;
            end
            ST_A1: begin
                mem_en      = 1'b1;
                mem_we      = r_we;
                mem_addr    = r_base + 32'd1;
                mem_wdata   = r_wdata[15:0];
                w_nextState = ST_FIN;
            end
            ST_FIN: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Request capture and starvation bookkeeping happen only on a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner     <= c_OWNER_FETCH;
            r_wide      <= 1'b0;
            r_we        <= 1'b0;
            r_base      <= 32'h0000_0000;
            r_wdata     <= 32'h0000_0000;
            r_starveCnt <= '0;
        end else if (w_accept) begin
            if (w_grantFetch) begin
                r_owner     <= c_OWNER_FETCH;
                r_wide      <= 1'b1;
                r_we        <= 1'b0;
                r_base      <= if_addr;
                r_wdata     <= 32'h0000_0000;
                r_starveCnt <= '0;
            end else begin
                r_owner <= c_OWNER_DATA;
                r_wide  <= dm_en32;
                r_we    <= dm_we;
                r_base  <= dm_addr;
                r_wdata <= dm_wdata;
                if (!if_req) begin
                    r_starveCnt <= '0;
                end else if (!w_starved) begin
                    r_starveCnt <= r_starveCnt + c_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resultHi <= 16'h0000;
            r_ifRdata  <= 32'h0000_0000;
            r_dmRdata  <= 32'h0000_0000;
        end else begin
            if ((r_state == ST_A1) && !r_we) begin
                r_resultHi <= mem_rdata;
            end
            if ((r_state == ST_FIN) && !r_we) begin
                if (r_owner == c_OWNER_FETCH) begin
                    r_ifRdata <= w_readResult;
                end else begin
                    r_dmRdata <= w_readResult;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed vector bench for mem_port_arbiter with a 16-bit
//               synchronous memory model behind the shared port.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic        dm_en32 = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        stall_fetch;
    logic        stall_mem;

    int nPass = 0;
    int nTotal = 0;

    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_en32(dm_en32), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_fetch(stall_fetch), .stall_mem(stall_mem)
    );

    // Memory model: read data appears the cycle after the beat.
    always @(posedge clk) begin
        if (!rst) begin
            mem[8'h10] <= 16'hABCD;
            mem[8'h11] <= 16'h1234;
            mem[8'hFF] <= 16'h1111;
            mem[8'h00] <= 16'h2222;
        end else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[7:0]] <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr[7:0]];
            end
        end
    end

    typedef struct {
        logic        isData;
        logic        we;
        logic        en32;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          expCycles;
        int          expBeats;
        logic [31:0] expLastAddr;
        logic [15:0] expWd0;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs [0:7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTotal++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic runTxn(input vec_t v, input string tag);
        int          doneCyc = 0;
        int          nBeats = 0;
        logic [31:0] firstAddr = '0;
        logic [31:0] lastAddr = '0;
        logic [15:0] firstWd = '0;
        logic        firstWe = 1'b0;
        logic        stallOk = 1'b1;
        logic        done;
        logic        stall;
        @(posedge clk); #1;
        if (v.isData) begin
            dm_req = 1'b1; dm_we = v.we; dm_en32 = v.en32;
            dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_en) begin
                if (nBeats == 0) begin
                    firstAddr = mem_addr; firstWd = mem_wdata; firstWe = mem_we;
                end
                lastAddr = mem_addr;
                nBeats++;
            end
            done  = v.isData ? dm_done : if_done;
            stall = v.isData ? stall_mem : stall_fetch;
            if (stall != (k < v.expCycles)) stallOk = 1'b0;
            if (done) begin
                doneCyc = k;
                break;
            end
        end
        @(posedge clk); #1;
        dm_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
        check({tag, " done cycle"}, doneCyc, v.expCycles);
        check({tag, " beats"}, nBeats, v.expBeats);
        check({tag, " first addr"}, firstAddr, v.addr);
        check({tag, " last addr"}, lastAddr, v.expLastAddr);
        check({tag, " first wdata"}, {16'h0, firstWd}, {16'h0, v.expWd0});
        check({tag, " we"}, {31'h0, firstWe}, {31'h0, v.we});
        check({tag, " stall"}, {31'h0, stallOk}, 32'd1);
        check({tag, " rdata"}, v.isData ? dm_rdata : if_rdata, v.expRdata);
    endtask

    // Fetch held against back-to-back 16-bit data reads at 0x20.
    task automatic runStarve(input string tag);
        int   dataDones = 0;
        int   ifDoneCyc = 0;
        logic ifNow;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_en32 = 1'b0; dm_addr = 32'h20; dm_wdata = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            ifNow = if_done;
            if (dm_done) dataDones++;
            if (ifNow) ifDoneCyc = k;
            @(posedge clk); #1;
            if (ifNow) begin
                if_req = 1'b0; dm_req = 1'b0;
                break;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        check({tag, " data grants before fetch"}, dataDones, 32'd4);
        check({tag, " fetch done cycle"}, ifDoneCyc, 32'd16);
        check({tag, " if_rdata"}, if_rdata, 32'hABCD_1234);
        check({tag, " dm_rdata"}, dm_rdata, 32'h0000_BEEF);
    endtask

    initial begin
        int   ifDoneCyc;
        int   dmDoneCyc;
        logic stall5;
        logic ifNow;
        logic dmNow;
        logic sawDone;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0,          4, 2, 32'h0000_0011, 16'h0000, 32'hABCD_1234};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_BEEF, 3, 1, 32'h0000_0020, 16'hBEEF, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0,          3, 1, 32'h0000_0020, 16'h0000, 32'h0000_BEEF};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_1357, 4, 2, 32'h0000_0031, 16'hCAFE, 32'h0000_BEEF};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_0030, 32'h0,          4, 2, 32'h0000_0031, 16'h0000, 32'hCAFE_1357};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0,          4, 2, 32'h0000_0000, 16'h0000, 32'h1111_2222};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h0000_0030, 32'h0,          4, 2, 32'h0000_0031, 16'h0000, 32'hCAFE_1357};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'hFFFF_5A5A, 3, 1, 32'h0000_0040, 16'h5A5A, 32'h1111_2222};

        repeat (3) @(negedge clk);
        check("reset if_rdata", if_rdata, 32'h0);
        check("reset dm_rdata", dm_rdata, 32'h0);
        check("reset mem bus", {mem_en, mem_we, mem_wdata, 14'h0}, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset done", {30'h0, if_done, dm_done}, 32'h0);
        #2 rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            runTxn(vecs[i], $sformatf("v%0d", i));
        end
        check("mem 0x40 written", {16'h0, mem[8'h40]}, 32'h0000_5A5A);

        // Simultaneous requests: data first, fetch in the IDLE after data's FIN.
        ifDoneCyc = 0; dmDoneCyc = 0; stall5 = 1'b0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_en32 = 1'b1; dm_addr = 32'h30; dm_wdata = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ifNow = if_done; dmNow = dm_done;
            if (dmNow) dmDoneCyc = k;
            if (ifNow) ifDoneCyc = k;
            if (k == 5) stall5 = stall_fetch;
            @(posedge clk); #1;
            if (dmNow) dm_req = 1'b0;
            if (ifNow) begin
                if_req = 1'b0;
                break;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        check("both dm done cycle", dmDoneCyc, 32'd4);
        check("both if done cycle", ifDoneCyc, 32'd8);
        check("both stall_fetch waiting", {31'h0, stall5}, 32'd1);
        check("both dm_rdata", dm_rdata, 32'hCAFE_1357);
        check("both if_rdata", if_rdata, 32'hABCD_1234);

        runStarve("starve1");
        runStarve("starve2");

        // Reset during A1 of a 32-bit read.
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b0; dm_en32 = 1'b1; dm_addr = 32'h30; dm_wdata = '0;
        repeat (3) @(negedge clk);
        check("abort A1 beat active", {mem_addr[31:1], mem_en}, {31'h18, 1'b1});
        #1 rst = 1'b0;
        #1;
        check("abort mem_en", {31'h0, mem_en}, 32'h0);
        check("abort mem_addr", mem_addr, 32'h0);
        check("abort dm_rdata", dm_rdata, 32'h0);
        check("abort if_rdata", if_rdata, 32'h0);
        sawDone = dm_done;
        repeat (2) begin
            @(negedge clk);
            if (dm_done) sawDone = 1'b1;
        end
        dm_req = 1'b0;
        #2 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (dm_done) sawDone = 1'b1;
        end
        check("abort no dm_done", {31'h0, sawDone}, 32'h0);
        runTxn(vecs[2], "after reset");

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive data grants allowed while if_req is pending before fetch is forced a grant.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset; clk and rst are the block's only clock and reset.
REQ-004 if_req  in  1  fetch requests a 32-bit instruction read; held until if_done.
REQ-005 if_addr  in  32  fetch word address; stable while if_req is high.
REQ-006 if_rdata  out  32  fetched instruction; first beat in [31:16].
REQ-007 if_done  out  1  one-cycle pulse marking fetch access completion.
REQ-008 dm_req  in  1  memory-stage request; held until dm_done.
REQ-009 dm_we  in  1  1 = write, 0 = read.
REQ-010 dm_en32  in  1  1 = 32-bit (two beats), 0 = 16-bit (one beat).
REQ-011 dm_addr  in  32  data word address.
REQ-012 dm_wdata  in  32  write data; 16-bit writes use [15:0].
REQ-013 dm_rdata  out  32  read data; 16-bit reads zero-extended.
REQ-014 dm_done  out  1  one-cycle completion pulse.
REQ-015 mem_en  out  1  memory port access strobe.
REQ-016 mem_we  out  1  memory port write enable.
REQ-017 mem_addr  out  32  memory port word address.
REQ-018 mem_wdata  out  16  memory port write data.
REQ-019 mem_rdata  in  16  memory read data, valid the cycle after an mem_en=1, mem_we=0 beat.
REQ-020 stall_fetch  out  1  combinational: if_req & ~if_done.
REQ-021 stall_mem  out  1  combinational: dm_req & ~dm_done.

Function
REQ-022 FSM states: IDLE, A0, A1, FIN; a registered owner bit (0 = fetch, 1 = data) plus latched wide flag (1 for fetch, dm_en32 for data) and latched we.
REQ-023 IDLE: if no request, stay; otherwise latch owner, address, we, wide, and wdata, then go to A0.
REQ-024 Priority: data over fetch, except fetch wins when starve count equals STARVE_LIMIT and if_req=1.
REQ-025 Starve counter: increments on each data grant made while if_req=1; clears on any fetch grant or when a data grant is made with if_req=0; saturates at STARVE_LIMIT.
REQ-026 A0: mem_en=1, mem_addr=base, mem_we=latched we, mem_wdata=wide ? wdata[31:16] : wdata[15:0]; next A1 if wide, else FIN.
REQ-027 A1: mem_en=1, mem_addr=base+1 (mod 2^32, 0xFFFFFFFF wraps to 0), mem_wdata=wdata[15:0]; for a read, capture mem_rdata into result[31:16]; next state FIN.
REQ-028 FIN: mem_en=0; for a read, capture mem_rdata into result [15:0] (wide) or {16'h0, mem_rdata} (narrow); pulse the owner's done for exactly one cycle; next IDLE.
REQ-029 The read result is written to the owner's rdata register at the FIN edge and held until that port's next read completes; writes leave rdata unchanged.
REQ-030 Latency from request sampled in IDLE: 16-bit access done in cycle 3, 32-bit access done in cycle 4 (IDLE=cycle 1).
REQ-031 A requester deasserts req on the edge ending its done cycle; req dropped mid-access is ignored and the access completes.
REQ-032 Outside A0/A1: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-033 Simultaneous if_req and dm_req in IDLE: REQ-024 decides; the loser waits, with its stall output held high.

Reset
REQ-034 While rst=0: state=IDLE, starve count=0, if_rdata=dm_rdata=0, if_done=dm_done=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, effective immediately and asynchronously.
REQ-035 Reset asserted mid-access aborts the access; no done pulse is issued and rdata is not updated.

Verification
REQ-036 Fetch only, if_addr=0x10, mem[0x10]=0xABCD, mem[0x11]=0x1234 -> mem_en in A0/A1 at addr 0x10/0x11; if_rdata=0xABCD1234; if_done pulses in cycle 4; stall_fetch high cycles 1-3.
REQ-037 Data 16-bit write, dm_addr=0x20, dm_wdata=0x0000BEEF -> one beat with mem_we=1, mem_addr=0x20, mem_wdata=0xBEEF; dm_done in cycle 3; dm_rdata unchanged.
REQ-038 if_req and dm_req (32-bit read) raised together -> data served first; fetch granted in the IDLE after data's FIN; both rdata values correct.
REQ-039 if_req held high while dm_req re-issued back-to-back -> after 4 data grants fetch is granted; starve count returns to 0.
REQ-040 32-bit read at dm_addr=0xFFFFFFFF -> second beat at mem_addr=0x00000000.
REQ-041 rst pulled low during A1 of a 32-bit read -> mem_en=0 immediately; no dm_done; dm_rdata=0; after release, a new request completes normally.
